// File: rtl/param_alu.sv
// param_alu: clocked ALU with persistent Z/C/N/V status, iterative one-bit-per-cycle shifts
// and one-hot register-file write enables.
module param_alu #(
    parameter  int WIDTH = 8,
    parameter  int NREGS = 4,
    parameter  int SHW   = $clog2(WIDTH) + 1,
    localparam int DW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [DW-1:0]    dst,
    input  logic             wb_en,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [NREGS-1:0] reg_we,
    output logic [3:0]       status
);
    localparam logic [3:0] OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBB = 4'd3;
    localparam logic [3:0] OP_CMP = 4'd4,  OP_AND = 4'd5,  OP_OR  = 4'd6,  OP_XOR = 4'd7;
    localparam logic [3:0] OP_NOT = 4'd8,  OP_SHL = 4'd9,  OP_SHR = 4'd10, OP_ASR = 4'd11;
    localparam logic [3:0] OP_ROL = 4'd12, OP_ROR = 4'd13, OP_MOV = 4'd14, OP_NOP = 4'd15;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [1:0]         sop_q, sop_d;
    logic [DW-1:0]      dst_q, dst_d;
    logic               wb_q, wb_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         status_q, status_d;
    logic               out_valid_q, out_valid_d;
    logic [NREGS-1:0]   reg_we_q, reg_we_d;

    logic               cin, op_c, op_v, shout, is_shift;
    logic [WIDTH:0]     add_w, sub_w;
    logic [WIDTH-1:0]   op_r, step;
    logic [SHW-1:0]     k;

    always_comb begin
        cin      = (op == OP_ADC || op == OP_SBB) && status_q[1];
        add_w    = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
        sub_w    = {1'b0, a} - {1'b0, b} - (WIDTH+1)'(cin);
        k        = b[SHW-1:0];
        is_shift = (op == OP_SHL || op == OP_SHR || op == OP_ASR);
        op_r     = a;
        op_c     = status_q[1];
        op_v     = 1'b0;
        case (op)
            OP_ADD, OP_ADC: begin
                op_r = add_w[WIDTH-1:0];
                op_c = add_w[WIDTH];
                op_v = (a[WIDTH-1] == b[WIDTH-1]) && (op_r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                op_r = sub_w[WIDTH-1:0];
                op_c = sub_w[WIDTH];
                op_v = (a[WIDTH-1] != b[WIDTH-1]) && (op_r[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: begin op_r = a & b; op_c = 1'b0; end
            OP_OR:  begin op_r = a | b; op_c = 1'b0; end
            OP_XOR: begin op_r = a ^ b; op_c = 1'b0; end
            OP_NOT: begin op_r = ~a;    op_c = 1'b0; end
            OP_MOV: begin op_r = b;     op_c = 1'b0; end
            OP_ROL: begin op_r = {a[WIDTH-2:0], a[WIDTH-1]}; op_c = a[WIDTH-1]; end
            OP_ROR: begin op_r = {a[0], a[WIDTH-1:1]};       op_c = a[0]; end
            default: ;
        endcase
        // sop 01 = SHL, 10 = SHR, 11 = ASR (sop[0] selects sign fill on right shifts)
        step  = (sop_q == 2'b01) ? {work_q[WIDTH-2:0], 1'b0} : {sop_q[0] & work_q[WIDTH-1], work_q[WIDTH-1:1]};
        shout = (sop_q == 2'b01) ? work_q[WIDTH-1] : work_q[0];
        state_d     = state_q;
        work_d      = work_q;
        cnt_d       = cnt_q;
        sop_d       = sop_q;
        dst_d       = dst_q;
        wb_d        = wb_q;
        result_d    = result_q;
        status_d    = status_q;
        out_valid_d = 1'b0;
        reg_we_d    = '0;
        if (state_q == IDLE) begin
            if (in_valid && is_shift && k != '0) begin
                state_d = SHIFT;
                work_d  = a;
                cnt_d   = (int'(k) > WIDTH) ? SHW'(WIDTH) : k;
                sop_d   = op[1:0];
                dst_d   = dst;
                wb_d    = wb_en;
            end else if (in_valid) begin
                out_valid_d = 1'b1;
                result_d    = (op == OP_NOP) ? result_q : op_r;
                status_d    = (op == OP_NOP) ? status_q : {op_v, op_r[WIDTH-1], op_c, op_r == '0};
                reg_we_d    = (wb_en && op != OP_CMP && op != OP_NOP) ? NREGS'(1) << dst : '0;
            end
        end else if (flush) begin
            state_d = IDLE;
        end else begin
            work_d = step;
            cnt_d  = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
                state_d     = IDLE;
                out_valid_d = 1'b1;
                result_d    = step;
                status_d    = {1'b0, step[WIDTH-1], shout, step == '0};
                reg_we_d    = wb_q ? NREGS'(1) << dst_q : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            cnt_q       <= '0;
            sop_q       <= '0;
            dst_q       <= '0;
            wb_q        <= 1'b0;
            result_q    <= '0;
            status_q    <= '0;
            out_valid_q <= 1'b0;
            reg_we_q    <= '0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            cnt_q       <= cnt_d;
            sop_q       <= sop_d;
            dst_q       <= dst_d;
            wb_q        <= wb_d;
            result_q    <= result_d;
            status_q    <= status_d;
            out_valid_q <= out_valid_d;
            reg_we_q    <= reg_we_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign reg_we    = reg_we_q;
    assign status    = status_q;
endmodule
